// File: rtl/sw_sched_pkg.sv
// Shared types and helpers for the Smith-Waterman result-FIFO read scheduler.
package sw_sched_pkg;

  // Defaults shared with the per-core result FIFO instantiations
  localparam int N_SRC_DEF = 4;
  localparam int WIDTH_DEF = 48;
  localparam int DEPTH_DEF = 5;

  // Widest request vector the round-robin search accepts
  localparam int MAX_SRC = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_OUT   = 2'd3
  } sched_state_t;

  // First requester at or after ptr, wrapping modulo n; returns 0 when nothing requests.
  // The loop runs high to low so the entry closest to ptr is the last one written.
  function automatic int rr_search(input logic [MAX_SRC-1:0] req, input int n, input int ptr);
    int                 idx;
    int                 k;
    logic [MAX_SRC-1:0] sh;
    idx = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (i < n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        sh = req >> k;
        if (sh[0]) idx = k;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester starting at the pointer.
module rr_arbiter
  import sw_sched_pkg::*;
#(
  parameter int N_SRC    = N_SRC_DEF,
  parameter int SEL_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0]    i_req,
  input  logic [SEL_BITS-1:0] i_rr_ptr,
  output logic [SEL_BITS-1:0] o_grant,
  output logic                o_any
);

  assign o_grant = SEL_BITS'(rr_search(MAX_SRC'(i_req), N_SRC, int'(i_rr_ptr)));
  assign o_any   = |i_req;

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler draining per-core result FIFOs into one valid/ready stream.
// Occupancy is shadowed from the FIFO write strobes and our own pops; each transfer
// spends two settling cycles before the single-cycle pop so the FIFO head is stable.
module fifo_rr_scheduler
  import sw_sched_pkg::*;
#(
  parameter int N_SRC    = N_SRC_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNT_BITS = $clog2(DEPTH + 1),
  parameter int SEL_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_SRC-1:0]       src_we,
  output logic [N_SRC-1:0]       src_re,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_BITS-1:0]    out_src,
  input  logic                   out_ready,
  output logic [N_SRC-1:0]       src_ovf,
  output logic                   busy
);

  sched_state_t         r_state;
  logic [SEL_BITS-1:0]  r_grant;
  logic [SEL_BITS-1:0]  r_rr_ptr;
  logic [WIDTH-1:0]     r_out_data;
  logic [SEL_BITS-1:0]  r_out_src;

  logic [SEL_BITS-1:0]  w_grant;
  logic                 w_any;
  logic [SEL_BITS-1:0]  w_ptr_next;
  logic [N_SRC-1:0]     w_req;
  logic [N_SRC-1:0]     w_pop;
  logic [WIDTH-1:0]     w_word [N_SRC];

  // The pop pulse is decoded straight from the WAIT2 state: one cycle, one-hot
  assign w_pop = (r_state == ST_WAIT2) ? (N_SRC'(1) << r_grant) : '0;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_ovf;

    // Source 0 sits in the MSBs of the packed head bus
    assign w_word[gi]  = src_data[(N_SRC-1-gi)*WIDTH +: WIDTH];
    assign w_req[gi]   = (r_cnt != '0);
    assign src_ovf[gi] = r_ovf;

    // Shadow occupancy: write adds, pop removes, both cancel; a write into a full FIFO is flagged
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        case ({src_we[gi], w_pop[gi]})
          2'b10: begin
            if (r_cnt == CNT_BITS'(DEPTH)) r_ovf <= 1'b1;
            else                           r_cnt <= r_cnt + CNT_BITS'(1);
          end
          2'b01:   r_cnt <= r_cnt - CNT_BITS'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  rr_arbiter #(
    .N_SRC    (N_SRC),
    .SEL_BITS (SEL_BITS)
  ) u_arb (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  assign w_ptr_next = (w_grant == SEL_BITS'(N_SRC - 1)) ? '0 : w_grant + SEL_BITS'(1);

  // Transfer sequencer: grant, two settling cycles, capture+pop, hold until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_any) begin
            r_grant  <= w_grant;
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_WAIT1;
          end
        end
        ST_WAIT1: r_state <= ST_WAIT2;
        ST_WAIT2: begin
          r_out_data <= w_word[r_grant];
          r_out_src  <= r_grant;
          r_state    <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign src_re    = w_pop;
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: single word, fairness, backpressure, overflow,
// simultaneous write/pop and mid-transfer reset.
module tb_fifo_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 48;
  localparam int SB = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   src_we = '0;
  logic [N*W-1:0] src_data = '0;
  logic [N-1:0]   src_re;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SB-1:0]  out_src;
  logic [N-1:0]   src_ovf;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fifo_rr_scheduler #(.N_SRC(N), .WIDTH(W), .DEPTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .src_we    (src_we),
    .src_re    (src_re),
    .src_data  (src_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .src_ovf   (src_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    src_data[(N-1-i)*W +: W] = v;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    if (out_valid) found = 1'b1;
    chk({tag, "_timeout"}, 64'(found), 64'(1));
  endtask

  task automatic wait_pop(input string tag, input logic [N-1:0] pat, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (src_re == pat) found = 1'b1;
      else tick();
    end
    chk({tag, "_timeout"}, 64'(found), 64'(1));
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      tick();
      if (out_valid) n++;
    end
  endtask

  // Pop pulses must be one-hot and separated by at least three idle cycles
  int low_run = 0;
  bit seen_re = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      seen_re <= 1'b0;
      low_run <= 0;
    end else if (src_re != '0) begin
      chk("re_onehot", 64'($onehot(src_re)), 64'(1));
      if (seen_re) chk("re_gap", 64'(low_run >= 3), 64'(1));
      seen_re <= 1'b1;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;

    // Reset values
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_re",    64'(src_re),    64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_src",   64'(out_src),   64'(0));
    chk("rst_ovf",   64'(src_ovf),   64'(0));
    rst = 1'b1;

    // Single word from source 2
    en = 1'b1;
    out_ready = 1'b1;
    set_word(2, 48'hABC);
    src_we = 4'b0100;
    tick();
    src_we = '0;
    chk("t1_idle_busy", 64'(busy), 64'(0));
    tick();
    chk("t1_grant_busy", 64'(busy),   64'(1));
    chk("t1_wait1_re",   64'(src_re), 64'(0));
    tick();
    chk("t1_pop",        64'(src_re),    64'(4'b0100));
    chk("t1_wait2_vld",  64'(out_valid), 64'(0));
    tick();
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_data",  64'(out_data),  64'(48'hABC));
    chk("t1_src",   64'(out_src),   64'(2));
    chk("t1_re_off", 64'(src_re),   64'(0));
    tick();
    chk("t1_done", 64'(out_valid), 64'(0));
    count_valid(10, n);
    chk("t1_no_extra", 64'(n), 64'(0));

    // Fairness: two words in every source, pointer restarted at 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    en = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 48'h0F00 + 48'(i));
    src_we = 4'b1111;
    tick();
    tick();
    src_we = '0;
    en = 1'b1;
    last = 0;
    for (int k = 0; k < 8; k++) begin
      wait_valid("fair", 8);
      chk("fair_src",  64'(out_src),  64'(k % 4));
      chk("fair_data", 64'(out_data), 64'(48'h0F00 + 48'(k % 4)));
      if (k > 0) chk("fair_gap", 64'(cyc - last), 64'(4));
      last = cyc;
      tick();
    end
    chk("fair_busy", 64'(busy), 64'(0));
    count_valid(8, n);
    chk("fair_no_extra", 64'(n), 64'(0));

    // Backpressure: source 0 held while source 1 waits
    out_ready = 1'b0;
    set_word(0, 48'hA0A0);
    set_word(1, 48'hB1B1);
    src_we = 4'b0011;
    tick();
    src_we = '0;
    wait_valid("bp0", 8);
    chk("bp_src0",  64'(out_src),  64'(0));
    chk("bp_data0", 64'(out_data), 64'(48'hA0A0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_vld",  64'(out_valid), 64'(1));
      chk("bp_hold_data", 64'(out_data),  64'(48'hA0A0));
      chk("bp_hold_src",  64'(out_src),   64'(0));
      chk("bp_no_pop",    64'(src_re),    64'(0));
    end
    out_ready = 1'b1;
    tick();
    wait_valid("bp1", 8);
    chk("bp_src1",  64'(out_src),  64'(1));
    chk("bp_data1", 64'(out_data), 64'(48'hB1B1));
    tick();

    // Overflow: six writes into source 3 while arbitration is disabled
    en = 1'b0;
    set_word(3, 48'hD3D3);
    src_we = 4'b1000;
    repeat (6) tick();
    src_we = '0;
    chk("ovf_flag", 64'(src_ovf), 64'(4'b1000));
    chk("ovf_idle", 64'(busy),    64'(0));
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid("ovf_drain", 8);
      chk("ovf_src", 64'(out_src), 64'(3));
      tick();
    end
    count_valid(12, n);
    chk("ovf_extra",  64'(n),       64'(0));
    chk("ovf_sticky", 64'(src_ovf), 64'(4'b1000));

    // Write to source 1 in the same cycle as its pop
    set_word(1, 48'h1111);
    src_we = 4'b0010;
    tick();
    src_we = '0;
    wait_pop("sim_pop", 4'b0010, 8);
    src_we = 4'b0010;
    tick();
    src_we = '0;
    set_word(1, 48'h2222);
    chk("sim_vld1",  64'(out_valid), 64'(1));
    chk("sim_src1",  64'(out_src),   64'(1));
    chk("sim_data1", 64'(out_data),  64'(48'h1111));
    tick();
    wait_valid("sim2", 8);
    chk("sim_src2",  64'(out_src),  64'(1));
    chk("sim_data2", 64'(out_data), 64'(48'h2222));
    tick();
    count_valid(12, n);
    chk("sim_extra", 64'(n), 64'(0));

    // Reset while a capture is pending
    out_ready = 1'b0;
    set_word(0, 48'hC0C0);
    src_we = 4'b0001;
    tick();
    src_we = '0;
    wait_pop("mrst_pop", 4'b0001, 8);
    rst = 1'b0;
    #1;
    chk("mrst_re",   64'(src_re),    64'(0));
    chk("mrst_vld",  64'(out_valid), 64'(0));
    chk("mrst_busy", 64'(busy),      64'(0));
    chk("mrst_ovf",  64'(src_ovf),   64'(0));
    chk("mrst_data", 64'(out_data),  64'(0));
    chk("mrst_src",  64'(out_src),   64'(0));
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    count_valid(12, n);
    chk("mrst_no_out", 64'(n), 64'(0));
    src_we = 4'b1001;
    tick();
    src_we = '0;
    wait_valid("mrst_ptr0", 8);
    chk("mrst_first", 64'(out_src), 64'(0));
    tick();
    wait_valid("mrst_ptr3", 8);
    chk("mrst_second", 64'(out_src), 64'(3));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
Round-robin read scheduler that drains N_SRC per-core result FIFOs of the Smith-Waterman array into one valid/ready output stream toward the CAPI result path. It shadows each FIFO's occupancy from the observed write strobes and its own pops. It issues single-cycle read pulses with the settling gaps the FIFOs require. It tags each output word with its source index and flags overflow per source.

Parameters:
N_SRC, 4, number of FIFOs/requesters
WIDTH, 48, FIFO data width
DEPTH, 5, entries per FIFO
CNT_BITS, $clog2(DEPTH+1), occupancy counter width
SEL_BITS, $clog2(N_SRC) (min 1), source index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  arbitration enable; 0 blocks new grants, does not abort in-flight transfer
src_we  in  N_SRC  copy of each FIFO's write strobe (one bit per source)
src_re  out  N_SRC  one-hot pop pulse to each FIFO
src_data  in  N_SRC*WIDTH  FIFO head outputs, source 0 in MSBs
out_valid  out  1  output word valid
out_data  out  WIDTH  captured word
out_src  out  SEL_BITS  source index of out_data
out_ready  in  1  downstream accept
src_ovf  out  N_SRC  sticky overflow flags
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=0): state IDLE, all cnt[i]=0, rr_ptr=0, out_valid=0, out_data=0, out_src=0, src_re=0, src_ovf=0, busy=0.
- Occupancy per source i, updated each edge:
  - we only: cnt+1.
  - pop only: cnt-1.
  - we and pop together: unchanged.
  - we with cnt==DEPTH and no pop: cnt holds, src_ovf[i] set (sticky until reset).
- Eligibility: req[i] = (cnt[i] != 0).
- Arbitration: round robin. Search starts at rr_ptr and wraps modulo N_SRC. On grant, rr_ptr <= grant+1 (wraps N_SRC-1 -> 0).
- FSM:
  - IDLE: if en and any req, latch grant index and go to WAIT1; else stay.
  - WAIT1: go to WAIT2. This cycle exists for FIFO head-output settling after a write into an empty FIFO.
  - WAIT2:
    - out_data <= src_data slice[grant].
    - out_src <= grant.
    - src_re[grant]=1 for exactly this cycle (combinational from state).
    - go to OUT.
  - OUT: out_valid=1; out_data and out_src held stable. If out_ready, go to IDLE; else stay.
- Latency: grant cycle t -> capture and pop at t+2 -> out_valid from t+3. Peak throughput is 1 word per 4 cycles.
- src_re is never asserted on two consecutive cycles. At least 3 low cycles separate pulses, as the FIFO read is edge-detected.
- src_re is only ever asserted for a source with cnt>0, so no pop of an empty FIFO.
- en deasserted mid-transfer: the current word completes through OUT; no new grant while en=0.
- A write to the granted source during WAIT1/WAIT2 updates cnt normally and does not disturb the capture.
- Reset asserted mid-operation: immediate return to reset values; any captured word is discarded.
- busy = (state != IDLE).

Decomposition:
- Shared package sw_sched_pkg:
  - FSM state encoding (IDLE, WAIT1, WAIT2, OUT).
  - function for round-robin next-grant search.
  - WIDTH/DEPTH defaults shared with the FIFO instantiations.
- One natural sub-module: rr_arbiter.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index and any-grant.
  - Parameterised on N_SRC, purely combinational.
- Occupancy counters are generated inline with a generate loop.

Test Plan:
- Single word: reset, src_we[2] pulse at cycle 0 with src_data[2]=48'hABC, out_ready=1. Grant at cycle 1, src_re=4'b0100 at cycle 3, out_valid at cycle 4 with out_data=48'hABC and out_src=2; cnt[2] returns to 0.
- Fairness: all 4 sources hold 2 words, out_ready=1, rr_ptr=0. Output source order is 0,1,2,3,0,1,2,3, one word every 4 cycles, then busy=0.
- Backpressure: out_ready=0 for 10 cycles while sources 0 and 1 are non-empty. out_valid stays 1 with constant data and src=0; no further src_re; source 1 is granted after the accept.
- Overflow: 6 src_we pulses to source 3 with en=0. cnt[3]=5 and src_ovf[3]=1. After en=1, exactly 5 words are drained and src_ovf[3] stays 1.
- Simultaneous write and pop: src_we[1] coincides with src_re[1] while cnt[1]=1. cnt[1] stays 1 and a second word from source 1 is emitted.
- Reset mid-transfer: rst=0 while in WAIT2/OUT. out_valid=0, src_re=0, all cnt=0, rr_ptr=0 immediately (asynchronously); no output after release without new writes.
